// File: rtl/de2_115_sopc_ir_pkg.sv
// Shared definitions for the NEC IR receiver: decoder states, register map,
// status bit positions and the pulse timing windows in microseconds.
`timescale 1ns/1ps
package de2_115_sopc_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } ir_state_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int STAT_VALID   = 0;
  localparam int STAT_REPEAT  = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_OVERRUN = 3;

  localparam int LEAD_MARK_MIN_US  = 8000;
  localparam int LEAD_MARK_MAX_US  = 10000;
  localparam int LEAD_SPACE_MIN_US = 4000;
  localparam int LEAD_SPACE_MAX_US = 5000;
  localparam int RPT_SPACE_MIN_US  = 2000;
  localparam int RPT_SPACE_MAX_US  = 2500;
  localparam int BIT_MARK_MIN_US   = 400;
  localparam int BIT_MARK_MAX_US   = 700;
  localparam int ZERO_SPACE_MIN_US = 400;
  localparam int ZERO_SPACE_MAX_US = 700;
  localparam int ONE_SPACE_MIN_US  = 1400;
  localparam int ONE_SPACE_MAX_US  = 1900;
  localparam int TIMEOUT_US        = 20000;

  function automatic logic in_win(input logic [15:0] v, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/de2_115_sopc_ir_sync_filter.sv
// Synchronizes the raw IR line, generates the 1 us tick and applies a
// 3-sample majority filter; emits filtered level plus one-cycle edge strobes.
`timescale 1ns/1ps
module de2_115_sopc_ir_sync_filter #(
  parameter int US_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_port,
  output logic tick,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  logic [PW-1:0] pre;
  logic [1:0]    sync;
  logic [1:0]    hist;
  logic          maj;

  assign tick = (pre == PW'(US_DIV - 1));
  // Two older samples plus the current synchronized one vote on the level.
  assign maj  = (hist[1] & hist[0]) | (hist[1] & sync[1]) | (hist[0] & sync[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre  <= '0;
      sync <= 2'b11;
      hist <= 2'b11;
      level <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[0], in_port};
      pre  <= tick ? '0 : pre + 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
      if (tick) begin
        hist  <= {hist[0], sync[1]};
        level <= maj;
        fall  <= level & ~maj;
        rise  <= ~level & maj;
      end
    end
  end

endmodule

// File: rtl/de2_115_sopc_ir_nec_rx.sv
// NEC infrared frame decoder with an Avalon-MM register file and level irq.
// Pulse widths are measured in 1 us ticks; WIN_DIV shrinks all windows for fast simulation.
`timescale 1ns/1ps
module de2_115_sopc_ir_nec_rx
  import de2_115_sopc_ir_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int US_DIV  = CLK_HZ / 1000000,
  parameter int WIN_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [15:0] LM_LO = 16'(LEAD_MARK_MIN_US / WIN_DIV);
  localparam logic [15:0] LM_HI = 16'(LEAD_MARK_MAX_US / WIN_DIV);
  localparam logic [15:0] LS_LO = 16'(LEAD_SPACE_MIN_US / WIN_DIV);
  localparam logic [15:0] LS_HI = 16'(LEAD_SPACE_MAX_US / WIN_DIV);
  localparam logic [15:0] RS_LO = 16'(RPT_SPACE_MIN_US / WIN_DIV);
  localparam logic [15:0] RS_HI = 16'(RPT_SPACE_MAX_US / WIN_DIV);
  localparam logic [15:0] BM_LO = 16'(BIT_MARK_MIN_US / WIN_DIV);
  localparam logic [15:0] BM_HI = 16'(BIT_MARK_MAX_US / WIN_DIV);
  localparam logic [15:0] ZS_LO = 16'(ZERO_SPACE_MIN_US / WIN_DIV);
  localparam logic [15:0] ZS_HI = 16'(ZERO_SPACE_MAX_US / WIN_DIV);
  localparam logic [15:0] OS_LO = 16'(ONE_SPACE_MIN_US / WIN_DIV);
  localparam logic [15:0] OS_HI = 16'(ONE_SPACE_MAX_US / WIN_DIV);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_US / WIN_DIV);

  logic        tick, ir_level, ir_fall, ir_rise;
  logic [15:0] pulse_cnt;

  ir_state_t   state, state_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [31:0] shreg, shreg_nxt;
  logic        is_rpt, is_rpt_nxt;
  logic        frame_done, rpt_done;

  logic [31:0] data_reg;
  logic [3:0]  status_reg, status_nxt;
  logic        irq_en;
  logic [31:0] rd_mux;
  logic        wr_en, wr_status;
  logic        unused_ok;

  de2_115_sopc_ir_sync_filter #(.US_DIV(US_DIV)) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .tick    (tick),
    .level   (ir_level),
    .fall    (ir_fall),
    .rise    (ir_rise)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
    end else if (ir_fall || ir_rise) begin
      pulse_cnt <= '0;
    end else if (tick && pulse_cnt != 16'hFFFF) begin
      pulse_cnt <= pulse_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      is_rpt  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      is_rpt  <= is_rpt_nxt;
    end
  end

  // pulse_cnt holds the width of the level that just ended when an edge strobe fires.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    is_rpt_nxt  = is_rpt;
    frame_done  = 1'b0;
    rpt_done    = 1'b0;
    if (state != IDLE && pulse_cnt > TO_LIM) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ir_fall) state_nxt = LEAD_MARK;
        LEAD_MARK:
          if (ir_rise) state_nxt = in_win(pulse_cnt, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
        LEAD_SPACE:
          if (ir_fall) begin
            if (in_win(pulse_cnt, LS_LO, LS_HI)) begin
              state_nxt   = BIT_MARK;
              bit_cnt_nxt = '0;
              is_rpt_nxt  = 1'b0;
            end else if (in_win(pulse_cnt, RS_LO, RS_HI)) begin
              state_nxt  = STOP_MARK;
              is_rpt_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        BIT_MARK:
          if (ir_rise) state_nxt = in_win(pulse_cnt, BM_LO, BM_HI) ? BIT_SPACE : IDLE;
        BIT_SPACE:
          if (ir_fall) begin
            if (in_win(pulse_cnt, ZS_LO, ZS_HI) || in_win(pulse_cnt, OS_LO, OS_HI)) begin
              shreg_nxt = {in_win(pulse_cnt, OS_LO, OS_HI), shreg[31:1]};
              if (bit_cnt == 5'd31) begin
                state_nxt = STOP_MARK;
              end else begin
                bit_cnt_nxt = bit_cnt + 5'd1;
                state_nxt   = BIT_MARK;
              end
            end else begin
              state_nxt = IDLE;
            end
          end
        STOP_MARK:
          if (ir_rise) begin
            state_nxt = IDLE;
            if (in_win(pulse_cnt, BM_LO, BM_HI)) begin
              frame_done = ~is_rpt;
              rpt_done   = is_rpt;
            end
          end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign wr_en     = chipselect & write;
  assign wr_status = wr_en && (address == ADDR_STATUS);

  // Clear first, then apply hardware sets so a completing frame is never lost.
  always_comb begin
    status_nxt = status_reg;
    if (wr_status) status_nxt = status_reg & ~writedata[3:0];
    if (frame_done) begin
      status_nxt[STAT_VALID] = 1'b1;
      if (status_reg[STAT_VALID]) status_nxt[STAT_OVERRUN] = 1'b1;
      if (shreg[31:24] != ~shreg[23:16]) status_nxt[STAT_ERROR] = 1'b1;
    end
    if (rpt_done) status_nxt[STAT_REPEAT] = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = data_reg;
      ADDR_STATUS:  rd_mux = {28'd0, status_reg};
      ADDR_CONTROL: rd_mux = {31'd0, irq_en};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= '0;
      status_reg <= '0;
      irq_en     <= 1'b0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      if (frame_done) data_reg <= shreg;
      status_reg <= status_nxt;
      if (wr_en && address == ADDR_CONTROL) irq_en <= writedata[0];
      readdata <= rd_mux;
      irq      <= irq_en & (status_reg[STAT_VALID] | status_reg[STAT_REPEAT]);
    end
  end

  assign unused_ok = &{1'b0, read, writedata[31:4], ir_level};

endmodule
